dct_row_serializer: RTL

//  Parallel-to-serial unpacker on the DCT output side. Accepts one 8-coefficient row
//  (8 x 12-bit signed, packed on a 96-bit bus) from the DCT and emits one coefficient
//  per cycle under valid/ready to the quantizer/zig-zag stage.

---
 rtl/dct_row_serializer_if.sv | 28 ++
 rtl/dct_row_serializer.sv | 112 +++++++++++
 2 files changed

// File: rtl/dct_row_serializer_if.sv
// Row-in / coefficient-out bus of the DCT row serializer.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender
// holds data and valid steady until that edge, and ready never depends on valid.
interface dct_row_serializer_if #(
  parameter int COEF_W   = 12,
  parameter int NUM_COEF = 8
);
  logic                         flush;
  logic [COEF_W*NUM_COEF-1:0]   row_data;
  logic                         row_valid;
  logic                         row_ready;
  logic [COEF_W-1:0]            coef_out;
  logic                         coef_valid;
  logic                         coef_ready;
  logic                         coef_last;
  logic                         blk_last;
  logic                         busy;

  modport slave (
    input  flush, row_data, row_valid, coef_ready,
    output row_ready, coef_out, coef_valid, coef_last, blk_last, busy
  );

  modport master (
    output flush, row_data, row_valid, coef_ready,
    input  row_ready, coef_out, coef_valid, coef_last, blk_last, busy
  );
endinterface

// File: rtl/dct_row_serializer.sv
// Unpacks 8-coefficient DCT rows into a one-coefficient-per-cycle stream, with a
// two-row buffer so the next row can land while the current one drains.
module dct_row_serializer #(
  parameter int COEF_W       = 12,
  parameter int NUM_COEF     = 8,
  parameter int ROWS_PER_BLK = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  dct_row_serializer_if.slave   bus,
  output logic [1:0]            state_dbg
);

  localparam int ROW_W = COEF_W * NUM_COEF;
  localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int RC_W  = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [ROW_W-1:0]  entry_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [RC_W-1:0]   row_cnt_q;

  logic              row_ready_int, coef_valid_int;
  logic              accept, pop, final_pop, lane_last;
  logic [ROW_W-1:0]  cur_row;

  // Handshake outputs come straight from the occupancy state, so coef_ready
  // never reaches row_ready combinationally.
  assign row_ready_int  = (state_q != S_FULL);
  assign coef_valid_int = (state_q != S_EMPTY);
  assign lane_last      = (idx_q == IDX_W'(NUM_COEF - 1));
  assign accept         = bus.row_valid && row_ready_int;
  assign pop            = coef_valid_int && bus.coef_ready;
  assign final_pop      = pop && lane_last;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else if (accept && !final_pop) begin
      case (state_q)
        S_EMPTY: state_d = S_ONE;
        S_ONE:   state_d = S_FULL;
        default: state_d = state_q;
      endcase
    end else if (!accept && final_pop) begin
      case (state_q)
        S_FULL:  state_d = S_ONE;
        S_ONE:   state_d = S_EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_EMPTY;
    else            state_q <= state_d;
  end

  // Flush clears only the bookkeeping; stale buffer contents are unreachable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      idx_q     <= '0;
      row_cnt_q <= '0;
    end else if (bus.flush) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      idx_q     <= '0;
      row_cnt_q <= '0;
    end else begin
      if (accept) begin
        entry_q[wr_ptr_q] <= bus.row_data;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        if (lane_last) begin
          idx_q     <= '0;
          rd_ptr_q  <= ~rd_ptr_q;
          row_cnt_q <= (row_cnt_q == RC_W'(ROWS_PER_BLK - 1)) ? '0 : row_cnt_q + RC_W'(1);
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign cur_row = entry_q[rd_ptr_q];

  always_comb begin
    bus.coef_out = '0;
    if (coef_valid_int) bus.coef_out = cur_row[int'(idx_q)*COEF_W +: COEF_W];
  end

  assign bus.row_ready  = row_ready_int;
  assign bus.coef_valid = coef_valid_int;
  assign bus.busy       = coef_valid_int;
  assign bus.coef_last  = coef_valid_int && lane_last;
  assign bus.blk_last   = coef_valid_int && lane_last &&
                          (row_cnt_q == RC_W'(ROWS_PER_BLK - 1));
  assign state_dbg      = state_q;

endmodule
